// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for the 5-stage MIPS pipeline plus the MDU busy sequencer.
// Optional HAZ_PERF_CNT_EN macro adds a 32-bit stall-cycle performance counter.
module hazard_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_addrD,
  input  logic [4:0]  rt_addrD,
  input  logic        branchD,
  input  logic        ctrl_xferD,
  input  logic        mdu_opD,
  input  logic        hilo_readD,
  input  logic        reg_writeE,
  input  logic        mem_to_regE,
  input  logic [4:0]  write_reg_addrE,
  input  logic        reg_writeM,
  input  logic        mem_to_regM,
  input  logic [4:0]  write_reg_addrM,
  input  logic        mdu_startE,
  input  logic        mdu_is_divE,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hitE, hitM;
  logic lw_stall, br_stall, mdu_stall, stall;
  logic busy, done;

  // $0 never carries a dependency, so it never matches.
  assign hitE = (write_reg_addrE != 5'd0) &&
                ((write_reg_addrE == rs_addrD) || (write_reg_addrE == rt_addrD));
  assign hitM = (write_reg_addrM != 5'd0) &&
                ((write_reg_addrM == rs_addrD) || (write_reg_addrM == rt_addrD));

  assign busy      = (state_q == BUSY);
  assign done      = busy && (cnt_q == '0);
  assign lw_stall  = mem_to_regE && reg_writeE && hitE;
  assign br_stall  = branchD && ((reg_writeE && hitE) || (mem_to_regM && hitM));
  assign mdu_stall = (hilo_readD || mdu_opD) && (busy || mdu_startE);
  assign stall     = lw_stall || br_stall || mdu_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start while BUSY is ignored; upstream stalls keep it from happening.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mdu_startE) begin
          state_d = BUSY;
          cnt_d   = mdu_is_divE ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output, combinational ones included, reads 0 while reset is held.
  assign stallF   = rst_n && stall;
  assign stallD   = rst_n && stall;
  assign flushE   = rst_n && stall;
  assign flushD   = rst_n && ctrl_xferD && !stall;
  assign mdu_busy = rst_n && busy;
  assign mdu_done = rst_n && done;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It generates stall and flush control for the F/D/E pipeline registers. It covers load-use hazards, branch-operand hazards in ID and control-transfer flushes. It also runs a small state machine that sequences the multi-cycle multiply/divide unit (MDU) and holds dependent instructions in ID until HI/LO is valid. Sits beside the EX forwarding unit; its outputs drive pipeline-register enables and clears.

Parameters:
MUL_CYCLES, 4, EX-side busy cycles for mult/multu (>=1)
DIV_CYCLES, 32, EX-side busy cycles for div/divu (>=1)
CNT_W, 6, MDU countdown width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs_addrD  in  5  rs of instruction in ID
rt_addrD  in  5  rt of instruction in ID
branchD  in  1  ID holds a conditional branch (compares rs/rt in ID)
ctrl_xferD  in  1  ID resolved a taken branch or jump this cycle
mdu_opD  in  1  ID holds mult/multu/div/divu
hilo_readD  in  1  ID holds mfhi/mflo
reg_writeE  in  1  EX instruction writes the register file
mem_to_regE  in  1  EX instruction is a load
write_reg_addrE  in  5  EX destination register
reg_writeM  in  1  MEM instruction writes the register file
mem_to_regM  in  1  MEM instruction is a load
write_reg_addrM  in  5  MEM destination register
mdu_startE  in  1  MDU op is in EX this cycle (one-cycle pulse per op)
mdu_is_divE  in  1  qualifies mdu_startE: 1 = div, 0 = mult
stallF  out  1  hold PC
stallD  out  1  hold IF/ID register
flushD  out  1  clear IF/ID register
flushE  out  1  clear ID/EX register (inserts a bubble)
mdu_busy  out  1  MDU in progress
mdu_done  out  1  one-cycle pulse in the last busy cycle
stall_cycles  out  32  stall cycle count (see Optional Feature)

Behaviour:
- A destination register "matches" an ID source only when the address is non-zero and equals rs_addrD or rt_addrD.
- lw_stall: mem_to_regE & reg_writeE & write_reg_addrE matches.
- br_stall: branchD & ((reg_writeE & write_reg_addrE matches) | (mem_to_regM & write_reg_addrM matches)).
- mdu_stall: (hilo_readD | mdu_opD) & (mdu_busy | mdu_startE).
- stall = lw_stall | br_stall | mdu_stall.
- Combinational outputs: stallF = stallD = flushE = stall.
- flushD = ctrl_xferD & ~stall. While stalled, the branch is unresolved and the flush must not fire.
- FSM states: IDLE, BUSY. Registered cnt[CNT_W-1:0].
  - IDLE & mdu_startE -> BUSY. cnt loads DIV_CYCLES-1 if mdu_is_divE, else MUL_CYCLES-1.
  - BUSY & cnt != 0 -> BUSY, cnt decrements by 1.
  - BUSY & cnt == 0 -> IDLE.
- mdu_busy = (state == BUSY). mdu_done = BUSY & cnt == 0.
- Timing: if mdu_startE is high in cycle t, mdu_busy is high in cycles t+1 .. t+N (N = selected cycle count). mfhi/mflo may leave ID in cycle t+N+1.
- mdu_startE while BUSY is illegal (upstream stalls prevent it). It is ignored: cnt is not reloaded. The bench flags it with an assertion.
- Reset (rst_n low, any time, including mid-BUSY): state = IDLE, cnt = 0, stall_cycles = 0. While rst_n is low, all outputs are forced to 0, including the combinational ones. An in-flight MDU op is abandoned.
- Release: first rising edge with rst_n high evaluates normally.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: stall_cycles is a 32-bit register, +1 on every clk edge where stall = 1. Wraps 0xFFFFFFFF -> 0. Cleared by reset.
- Undefined: stall_cycles is tied to 32'd0 and no counter flops are synthesised.

Test Plan:
- Load-use: E = lw $8 (mem_to_regE=1, reg_writeE=1, addrE=8), D rs=8 -> stallF/stallD/flushE = 1 for exactly 1 cycle; same case with addrE=0 -> all 0.
- Branch operand: branchD=1, rt_addrD=9, E writes $9 (ALU op) -> 1-cycle stall. Then lw $9 in M -> 1 more stall cycle. ctrl_xferD held high throughout -> flushD = 0 during stall, 1 on the first unstalled cycle.
- Mult sequencing: mdu_startE=1, mdu_is_divE=0 at cycle t, hilo_readD=1 -> stall cycles t..t+4, mdu_busy t+1..t+4, mdu_done at t+4, stall released at t+5.
- Div back-to-back: div issued, then mdu_opD=1 -> stall for 33 cycles total (DIV_CYCLES=32). The second op enters EX only after mdu_busy falls.
- Async reset mid-div: assert rst_n=0 at cnt=17 between clock edges -> all outputs 0 immediately. After release, state IDLE, no mdu_done pulse.
- With HAZ_PERF_CNT_EN: run the mult scenario -> stall_cycles = 5. Preload/force counter to 0xFFFFFFFF and stall once -> reads 0. Without the macro -> stall_cycles = 0 throughout.
